// File: rtl/ei_axi4_slave_pkg.sv
// Shared types for the AXI4 slave memory: burst codes, response codes,
// FSM state encodings and burst legality helpers.
package ei_axi4_slave_pkg;

  typedef enum logic [1:0] {
    BURST_FIXED = 2'b00,
    BURST_INCR  = 2'b01,
    BURST_WRAP  = 2'b10
  } burst_t;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic [1:0] {
    W_IDLE,
    W_DATA,
    W_RESP
  } wr_state_t;

  typedef enum logic {
    R_IDLE,
    R_DATA
  } rd_state_t;

  function automatic logic wrap_len_ok(
    input logic [7:0] len
  );
    return (len == 8'd1) || (len == 8'd3) ||
           (len == 8'd7) || (len == 8'd15);
  endfunction

  // Reserved encoding, or WRAP with an unsupported length.
  function automatic logic burst_illegal(
    input logic [1:0] burst,
    input logic [7:0] len
  );
    return (burst == 2'b11) ||
           ((burst == BURST_WRAP) && !wrap_len_ok(len));
  endfunction

endpackage

// File: rtl/ei_axi4_burst_addr_gen.sv
// Burst address walker: load start/len/burst, step once per beat.
// Ports: load/step controls; addr (current), next_addr, last, last_next, illegal.
module ei_axi4_burst_addr_gen
  import ei_axi4_slave_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load,
  input  logic [ADDR_W-1:0] start_addr,
  input  logic [7:0]        len,
  input  logic [1:0]        burst,
  input  logic              step,
  output logic [ADDR_W-1:0] addr,
  output logic [ADDR_W-1:0] next_addr,
  output logic              last,
  output logic              last_next,
  output logic              illegal
);

  localparam int BYTES = DATA_W / 8;
  localparam int SZ    = $clog2(BYTES);

  burst_t            mode;
  logic [7:0]        len_q;
  logic [7:0]        cnt;
  logic [ADDR_W-1:0] addr_q;
  logic [ADDR_W-1:0] inc;
  logic [ADDR_W-1:0] wmask;
  logic              ill_q;

  // (len+1)*BYTES-1 == (len<<SZ) | (BYTES-1)
  always_comb begin
    inc       = addr_q + ADDR_W'(BYTES);
    wmask     = (ADDR_W'(len_q) << SZ) |
                ADDR_W'(BYTES - 1);
    next_addr = inc;
    unique case (1'b1)
      mode == BURST_FIXED:
        next_addr = addr_q;
      mode == BURST_WRAP:
        next_addr = (addr_q & ~wmask) |
                    (inc & wmask);
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mode   <= BURST_INCR;
      len_q  <= '0;
      cnt    <= '0;
      addr_q <= '0;
      ill_q  <= 1'b0;
    end else if (load) begin
      ill_q  <= burst_illegal(burst, len);
      mode   <= burst_illegal(burst, len) ?
                BURST_INCR : burst_t'(burst);
      len_q  <= len;
      cnt    <= '0;
      addr_q <= start_addr;
    end else if (step) begin
      addr_q <= next_addr;
      cnt    <= cnt + 8'd1;
    end
  end

  assign addr      = addr_q;
  assign last      = (cnt == len_q);
  assign last_next = ((cnt + 8'd1) == len_q);
  assign illegal   = ill_q;

endmodule

// File: rtl/ei_axi4_slave_mem.sv
// AXI4 slave memory, independent single-outstanding write and read paths.
// Ports: AW/W/B write channels, AR/R read channels, aclk, aresetn.
module ei_axi4_slave_mem
  import ei_axi4_slave_pkg::*;
#(
  parameter int DATA_W    = 32,
  parameter int ADDR_W    = 32,
  parameter int ID_W      = 4,
  parameter int MEM_DEPTH = 256
) (
  input  logic                aclk,
  input  logic                aresetn,
  input  logic [ID_W-1:0]     awid,
  input  logic [ADDR_W-1:0]   awaddr,
  input  logic [7:0]          awlen,
  input  logic [1:0]          awburst,
  input  logic                awvalid,
  output logic                awready,
  input  logic [DATA_W-1:0]   wdata,
  input  logic [DATA_W/8-1:0] wstrb,
  input  logic                wlast,
  input  logic                wvalid,
  output logic                wready,
  output logic [ID_W-1:0]     bid,
  output logic [1:0]          bresp,
  output logic                bvalid,
  input  logic                bready,
  input  logic [ID_W-1:0]     arid,
  input  logic [ADDR_W-1:0]   araddr,
  input  logic [7:0]          arlen,
  input  logic [1:0]          arburst,
  input  logic                arvalid,
  output logic                arready,
  output logic [ID_W-1:0]     rid,
  output logic [DATA_W-1:0]   rdata,
  output logic [1:0]          rresp,
  output logic                rlast,
  output logic                rvalid,
  input  logic                rready
);

  localparam int BYTES = DATA_W / 8;
  localparam int SZ    = $clog2(BYTES);
  localparam int IDX_W = $clog2(MEM_DEPTH);

  logic [DATA_W-1:0] mem [MEM_DEPTH];

  wr_state_t w_state;
  rd_state_t r_state;
  logic      w_err;

  logic [ADDR_W-1:0] w_addr, w_next;
  logic [ADDR_W-1:0] r_addr, r_next;
  logic w_last, w_last_next, w_ill;
  logic r_last, r_last_next, r_ill;

  logic aw_hs, w_hs, ar_hs, r_hs;
  logic w_in, w_err_now;
  logic [ADDR_W-1:0] r_src;
  logic r_in;
  logic [DATA_W-1:0] r_word;
  logic unused_gen;

  function automatic logic in_range(
    input logic [ADDR_W-1:0] a
  );
    return (a >> (SZ + IDX_W)) == '0;
  endfunction

  assign aw_hs = awvalid && awready;
  assign w_hs  = wvalid && wready;
  assign ar_hs = arvalid && arready;
  assign r_hs  = rvalid && rready;

  ei_axi4_burst_addr_gen #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W)
  ) u_wgen (
    .clk        (aclk),
    .rst_n      (aresetn),
    .load       (aw_hs),
    .start_addr (awaddr),
    .len        (awlen),
    .burst      (awburst),
    .step       (w_hs),
    .addr       (w_addr),
    .next_addr  (w_next),
    .last       (w_last),
    .last_next  (w_last_next),
    .illegal    (w_ill)
  );

  ei_axi4_burst_addr_gen #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W)
  ) u_rgen (
    .clk        (aclk),
    .rst_n      (aresetn),
    .load       (ar_hs),
    .start_addr (araddr),
    .len        (arlen),
    .burst      (arburst),
    .step       (r_hs),
    .addr       (r_addr),
    .next_addr  (r_next),
    .last       (r_last),
    .last_next  (r_last_next),
    .illegal    (r_ill)
  );

  assign unused_gen = ^{w_next, w_last_next, r_addr};

  assign w_in      = in_range(w_addr);
  assign w_err_now = w_err || w_ill || !w_in ||
                     (wlast != w_last);

  // Beat 0 comes from araddr; later beats look one step ahead.
  assign r_src  = (r_state == R_IDLE) ? araddr : r_next;
  assign r_in   = in_range(r_src);
  assign r_word = mem[r_src[SZ +: IDX_W]];

  always_ff @(posedge aclk) begin
    if (w_hs && w_in) begin
      for (int b = 0; b < BYTES; b++) begin
        if (wstrb[b]) begin
          mem[w_addr[SZ +: IDX_W]][8*b +: 8]
            <= wdata[8*b +: 8];
        end
      end
    end
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      w_state <= W_IDLE;
      awready <= 1'b0;
      wready  <= 1'b0;
      bvalid  <= 1'b0;
      bid     <= '0;
      bresp   <= RESP_OKAY;
      w_err   <= 1'b0;
    end else begin
      unique case (w_state)
        W_IDLE: begin
          if (aw_hs) begin
            awready <= 1'b0;
            wready  <= 1'b1;
            bid     <= awid;
            w_err   <= 1'b0;
            w_state <= W_DATA;
          end else begin
            awready <= 1'b1;
          end
        end
        W_DATA: begin
          if (w_hs) begin
            w_err <= w_err_now;
            if (w_last) begin
              wready  <= 1'b0;
              bvalid  <= 1'b1;
              bresp   <= w_err_now ?
                         RESP_SLVERR : RESP_OKAY;
              w_state <= W_RESP;
            end
          end
        end
        W_RESP: begin
          if (bready) begin
            bvalid  <= 1'b0;
            awready <= 1'b1;
            w_state <= W_IDLE;
          end
        end
        default: w_state <= W_IDLE;
      endcase
    end
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      r_state <= R_IDLE;
      arready <= 1'b0;
      rvalid  <= 1'b0;
      rlast   <= 1'b0;
      rid     <= '0;
      rdata   <= '0;
      rresp   <= RESP_OKAY;
    end else begin
      unique case (r_state)
        R_IDLE: begin
          if (ar_hs) begin
            arready <= 1'b0;
            rvalid  <= 1'b1;
            rid     <= arid;
            rdata   <= r_in ? r_word : '0;
            rresp   <= (burst_illegal(arburst, arlen) ||
                        !r_in) ? RESP_SLVERR : RESP_OKAY;
            rlast   <= (arlen == 8'd0);
            r_state <= R_DATA;
          end else begin
            arready <= 1'b1;
          end
        end
        R_DATA: begin
          if (r_hs) begin
            if (r_last) begin
              rvalid  <= 1'b0;
              rlast   <= 1'b0;
              arready <= 1'b1;
              r_state <= R_IDLE;
            end else begin
              rdata <= r_in ? r_word : '0;
              rresp <= (r_ill || !r_in) ?
                       RESP_SLVERR : RESP_OKAY;
              rlast <= r_last_next;
            end
          end
        end
        default: r_state <= R_IDLE;
      endcase
    end
  end

endmodule
